haar_stream_xform: RTL

- Parametrised streaming successor to the fixed 8-byte, 3-level sum/difference decomposition tree of the image compression pipeline.
- Accepts N unsigned pixels serially over a valid/ready handshake and buffers them.
- Runs LEVELS in-place Haar butterfly levels, one level per clock.
- Streams N signed coefficients out in Mallat order (coarsest low band first) to the downstream quantiser/reconstruction stage.

---
 rtl/haar_pkg.sv | 29 ++
 rtl/haar_butterfly.sv | 32 +++
 rtl/haar_stream_xform.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/haar_pkg.sv
// Shared types and sizing helpers for the streaming Haar transform.
// Optional build macro used by this design: HAAR_NORM_EN (normalised butterflies).
package haar_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width of the sample/coefficient index counter for an N-point block.
    function automatic int cnt_w(input int n);
        return clog2(n);
    endfunction

    // Width of the level counter; must be able to hold 0..levels.
    function automatic int lvl_w(input int levels);
        return clog2(levels + 1);
    endfunction

endpackage

// File: rtl/haar_butterfly.sv
// One Haar butterfly: low band and high band of a sample pair.
// HAAR_NORM_EN defined: both bands are halved with floor (arithmetic shift).
// HAAR_NORM_EN undefined: plain sum and difference.
module haar_butterfly #(
    parameter int OW = 12
) (
    input  logic signed [OW-1:0] a,
    input  logic signed [OW-1:0] b,
    output logic signed [OW-1:0] lo,
    output logic signed [OW-1:0] hi
);

`ifdef HAAR_NORM_EN
    logic signed [OW:0] sum;
    logic signed [OW:0] dif;

    // Widen by one bit before halving so the floor is exact.
    always_comb begin
        sum = {a[OW-1], a} + {b[OW-1], b};
        dif = {a[OW-1], a} - {b[OW-1], b};
        lo  = OW'(sum >>> 1);
        hi  = OW'(dif >>> 1);
    end
`else
    // Coefficient width is sized so the full-precision result always fits.
    always_comb begin
        lo = a + b;
        hi = a - b;
    end
`endif

endmodule

// File: rtl/haar_stream_xform.sv
// Streaming N-point, LEVELS-level Haar decomposition.
// Loads N pixels, runs one in-place butterfly level per clock, then streams
// coefficients out in Mallat order. Honours HAAR_NORM_EN via haar_butterfly.
//
// state   | meaning
// LOAD    | accepting pixels into the buffer
// COMPUTE | one butterfly level per cycle over the active low band
// OUTPUT  | streaming buffer contents downstream
module haar_stream_xform
    import haar_pkg::*;
#(
    parameter int DW     = 8,
    parameter int N      = 8,
    parameter int LEVELS = 3,
    // Derived coefficient width; leave at its default.
    parameter int OW     = DW + LEVELS + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int CNT_W = cnt_w(N);
    localparam int LVL_W = lvl_w(LEVELS);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc;
    logic [LVL_W-1:0]      lvl_q;
    logic signed [OW-1:0]  mem_q [N];
    logic signed [OW-1:0]  mem_d [N];
    logic signed [OW-1:0]  lo    [N/2];
    logic signed [OW-1:0]  hi    [N/2];
    logic                  in_fire, out_fire, cnt_end, lvl_end;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign cnt_end  = (cnt_q == CNT_W'(N - 1));
    assign lvl_end  = (lvl_q == LVL_W'(LEVELS - 1));
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Fixed pairing (2i, 2i+1); only the active low band is written back.
    for (genvar g = 0; g < N / 2; g++) begin : g_bf
        haar_butterfly #(.OW(OW)) u_bf (
            .a  (mem_q[2*g]),
            .b  (mem_q[2*g+1]),
            .lo (lo[g]),
            .hi (hi[g])
        );
    end

    // Next buffer contents for one level: lows to [0,M/2), highs to [M/2,M).
    always_comb begin
        int               half;
        logic [CNT_W-1:0] hidx;
        for (int j = 0; j < N; j++) mem_d[j] = mem_q[j];
        half = (N / 2) >> lvl_q;
        hidx = '0;
        for (int i = 0; i < N / 2; i++) begin
            if (i < half) begin
                hidx        = CNT_W'(i + half);
                mem_d[i]    = lo[i];
                mem_d[hidx] = hi[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_fire && cnt_end)           state_d = COMPUTE;
            COMPUTE: if (lvl_end)                      state_d = OUTPUT;
            OUTPUT:  if (out_fire && out_last)         state_d = LOAD;
            default:                                   state_d = LOAD;
        endcase
    end

    // Handshake and status outputs; in_ready is held low during reset.
    always_comb begin
        in_ready = (state_q == LOAD) && !rst;
        busy     = (state_q != LOAD);
    end

    // Buffer, counters and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) mem_q[j] <= '0;
            cnt_q     <= '0;
            lvl_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        mem_q[cnt_q] <= {{(OW-DW){1'b0}}, in_data};
                        if (cnt_end) begin
                            cnt_q <= '0;
                            lvl_q <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                COMPUTE: begin
                    for (int j = 0; j < N; j++) mem_q[j] <= mem_d[j];
                    lvl_q <= lvl_q + LVL_W'(1);
                end
                OUTPUT: begin
                    // First OUTPUT cycle primes the output register from buf[0].
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= mem_q[cnt_q];
                        out_last  <= cnt_end;
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q     <= cnt_inc;
                            out_data  <= mem_q[cnt_inc];
                            out_last  <= (cnt_inc == CNT_W'(N - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
